ami_channel_arbiter: RTL and testbench
======================================

// Module: ami_channel_arbiter
// PURPOSE
//  Shares one AMI memory channel between NUM_REQ requesters (app/port pairs).
//  Round-robin arbitration onto the channel request path. In-order response routing back to the issuer via a route FIFO.
//  Sits between the per-app AMI ports and one per-channel AMI-to-SimpleDRAM converter.
// PARAMETERS
//  NUM_REQ      4   number of requesters sharing the channel (>=2)
//  ROUTE_DEPTH  16  max outstanding reads on the channel (power of 2)
// PORTS
//  clk                single clock
//  rst                reset, synchronous, active-high
//  req_enable         in   NUM_REQ                      per-requester enable; 0 masks arbitration
//  req_in             in   AMIRequest[NUM_REQ]          requests; .valid qualifies
//  req_grant_out      out  1[NUM_REQ]                   request consumed this cycle
//  resp_out           out  AMIResponse[NUM_REQ]         routed responses
//  resp_grant_in      in   1[NUM_REQ]                   requester accepts resp_out
//  ch_req_out         out  AMIRequest                   request to channel converter
//  ch_req_grant_in    in   1                            converter accepts ch_req_out
//  ch_resp_in         in   AMIResponse                  channel response, in issue order
//  ch_resp_grant_out  out  1                            response consumed
//  err_orphan_resp    out  1                            sticky: response arrived with no outstanding read
//  stat_grants        out  32[NUM_REQ]                  grant counters (see CONFIGURATION)
// BEHAVIOUR
//  - Handshake: transfer occurs when valid && grant in the same cycle; grant is combinational, zero latency.
//  - Eligible(i) = req_in[i].valid && req_enable[i] && !(read && route_full).
//    Writes are never blocked by route_full.
//  - Selection: first eligible index at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
//    ch_req_out = req_in[sel] with .valid=1; .valid=0 when none eligible.
//  - req_grant_out[sel] = ch_req_grant_in; all other grants 0.
//  - On a transfer: rr_ptr <= sel+1 (mod NUM_REQ); if read, push sel into route FIFO. No transfer: rr_ptr holds.
//  - Response: ch_resp_in.valid && FIFO non-empty -> resp_out[head] = ch_resp_in; others .valid=0.
//    ch_resp_grant_out = resp_grant_in[head]; pop on that handshake.
//  - Response with FIFO empty: ch_resp_grant_out=1 (drop), set err_orphan_resp; cleared only by rst.
//  - Full: route_full blocks read grants even if a pop occurs in the same cycle (no bypass).
//  - Simultaneous push and pop: allowed when not full; count unchanged.
//  - req_enable deassert mid-flight: new grants stop next cycle.
//    Already-issued reads still route back to that requester.
//  - Reset: rr_ptr=0, FIFO empty, all grants 0, all .valid outputs 0, err_orphan_resp=0, stat_grants=0.
//    Reset mid-operation discards outstanding routing; the channel is reset together with this block.
//  - Widths: rr_ptr and FIFO entries are $clog2(NUM_REQ) bits; count is $clog2(ROUTE_DEPTH)+1 bits.
// CONFIGURATION
//  AMI_ARB_STATS_EN defined:
//    stat_grants[i] increments on each request transfer of requester i; saturates at 32'hFFFF_FFFF; cleared by rst.
//  AMI_ARB_STATS_EN undefined:
//    stat_grants tied to 0, no counter logic; all other behaviour is identical.
// STRUCTURE
//  - AMITypes package: AMIRequest/AMIResponse (existing); add AMI_ARB_ROUTE_DEPTH default constant.
//  - Sub-module ami_route_fifo: synchronous FIFO of requester indices (push, pop, full, empty, head).
//  - Arbiter, response mux and stats counters stay in this module.
// TESTING
//  1 NUM_REQ=4, all reqs valid reads, ch grant=1 -> grants in order 0,1,2,3,0; responses routed 0,1,2,3.
//  2 Only req 2 valid, ch grant stalled 3 cycles then 1 -> req_grant_out[2] rises on cycle 4 only; rr_ptr=3.
//  3 16 reads issued with no responses -> 17th read not granted; a write from req 1 still granted.
//    Then one pop -> the next read is granted the following cycle.
//  4 resp_grant_in[head]=0 for 5 cycles -> ch_resp_grant_out=0 and resp_out held; FIFO count unchanged.
//  5 ch_resp_in.valid with FIFO empty -> ch_resp_grant_out=1, err_orphan_resp=1 until rst.
//  6 With AMI_ARB_STATS_EN: 10 grants to req 0 -> stat_grants[0]=10; rst mid-burst -> all outputs/counters 0 next cycle.

Source files
------------

// File: rtl/ami_channel_arbiter_pkg.sv
// Shared AMI request/response types and channel-arbiter defaults.
package ami_channel_arbiter_pkg;

  localparam int AMI_ADDR_W          = 64;
  localparam int AMI_DATA_W          = 512;
  localparam int AMI_ARB_ROUTE_DEPTH = 16;

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
    logic [7:0]            size;
  } AMIRequest;

  typedef struct packed {
    logic                  valid;
    logic [AMI_DATA_W-1:0] data;
    logic [7:0]            size;
  } AMIResponse;

endpackage

// File: rtl/ami_route_fifo.sv
// Synchronous FIFO of requester indices; remembers read issue order for response routing.
module ami_route_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ami_channel_arbiter.sv
// Round-robin share of one AMI channel among NUM_REQ requesters with in-order response routing.
// Optional grant statistics enabled by defining AMI_ARB_STATS_EN.
module ami_channel_arbiter
  import ami_channel_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ROUTE_DEPTH = AMI_ARB_ROUTE_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_enable,
  input  AMIRequest  [NUM_REQ-1:0]      req_in,
  output logic [NUM_REQ-1:0]            req_grant_out,
  output AMIResponse [NUM_REQ-1:0]      resp_out,
  input  logic [NUM_REQ-1:0]            resp_grant_in,
  output AMIRequest                     ch_req_out,
  input  logic                          ch_req_grant_in,
  input  AMIResponse                    ch_resp_in,
  output logic                          ch_resp_grant_out,
  output logic                          err_orphan_resp,
  output logic [NUM_REQ-1:0][31:0]      stat_grants
);
  localparam int PW = $clog2(NUM_REQ);

  function automatic logic [PW-1:0] wrap_idx(input int v);
    return PW'(v % NUM_REQ);
  endfunction

  logic [PW-1:0]      rr_ptr, sel, head;
  logic [NUM_REQ-1:0] elig;
  logic               found, xfer, push, pop, orphan_set;
  logic               fifo_full, fifo_empty;

  // Reads need a route slot; writes never produce a response so are never held off.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_in[i].valid && req_enable[i] && !(!req_in[i].is_write && fifo_full);
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig[wrap_idx(int'(rr_ptr) + k)]) begin
        found = 1'b1;
        sel   = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  always_comb begin
    ch_req_out    = '0;
    req_grant_out = '0;
    if (!rst && found) begin
      ch_req_out          = req_in[sel];
      ch_req_out.valid    = 1'b1;
      req_grant_out[sel]  = ch_req_grant_in;
    end
  end

  assign xfer = !rst && found && ch_req_grant_in;
  assign push = xfer && !req_in[sel].is_write;

  always_ff @(posedge clk) begin
    if (rst)       rr_ptr <= '0;
    else if (xfer) rr_ptr <= wrap_idx(int'(sel) + 1);
  end

  ami_route_fifo #(.W(PW), .DEPTH(ROUTE_DEPTH)) u_route_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sel),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Responses with nothing outstanding are swallowed so the channel cannot wedge.
  always_comb begin
    resp_out          = '0;
    ch_resp_grant_out = 1'b0;
    pop               = 1'b0;
    orphan_set        = 1'b0;
    if (!rst && ch_resp_in.valid) begin
      if (fifo_empty) begin
        ch_resp_grant_out = 1'b1;
        orphan_set        = 1'b1;
      end else begin
        resp_out[head]    = ch_resp_in;
        ch_resp_grant_out = resp_grant_in[head];
        pop               = resp_grant_in[head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             err_orphan_resp <= 1'b0;
    else if (orphan_set) err_orphan_resp <= 1'b1;
  end

`ifdef AMI_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [31:0] cnt;
    always_ff @(posedge clk) begin
      if (rst)                                   cnt <= '0;
      else if (xfer && sel == PW'(i) && cnt != '1) cnt <= cnt + 32'd1;
    end
    assign stat_grants[i] = cnt;
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_ami_channel_arbiter.sv
// Directed self-checking bench for ami_channel_arbiter (NUM_REQ=4, ROUTE_DEPTH=16).
module tb_ami_channel_arbiter;
  import ami_channel_arbiter_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0]             req_enable;
  AMIRequest  [3:0]       req_in;
  logic [3:0]             req_grant_out;
  AMIResponse [3:0]       resp_out;
  logic [3:0]             resp_grant_in;
  AMIRequest              ch_req_out;
  logic                   ch_req_grant_in;
  AMIResponse             ch_resp_in;
  logic                   ch_resp_grant_out;
  logic                   err_orphan_resp;
  logic [3:0][31:0]       stat_grants;

  int n_checks = 0;
  int n_fail   = 0;

  ami_channel_arbiter #(.NUM_REQ(4), .ROUTE_DEPTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_enable        (req_enable),
    .req_in            (req_in),
    .req_grant_out     (req_grant_out),
    .resp_out          (resp_out),
    .resp_grant_in     (resp_grant_in),
    .ch_req_out        (ch_req_out),
    .ch_req_grant_in   (ch_req_grant_in),
    .ch_resp_in        (ch_resp_in),
    .ch_resp_grant_out (ch_resp_grant_out),
    .err_orphan_resp   (err_orphan_resp),
    .stat_grants       (stat_grants)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then let drives settle away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr, input logic [63:0] a);
    req_in[i].valid    = v;
    req_in[i].is_write = wr;
    req_in[i].addr     = a;
  endtask

  task automatic set_resp(input logic v, input logic [63:0] d);
    ch_resp_in.valid      = v;
    ch_resp_in.data       = '0;
    ch_resp_in.data[63:0] = d;
  endtask

  logic [31:0] exp_stat;

  initial begin
    rst = 1'b1; req_enable = '0; req_in = '0; resp_grant_in = '0;
    ch_req_grant_in = 1'b0; ch_resp_in = '0;
    step(); step();
    chk("rst_grant", 64'(req_grant_out), 64'h0);
    chk("rst_err", 64'(err_orphan_resp), 64'h0);
    chk("rst_stat0", 64'(stat_grants[0]), 64'h0);
    rst = 1'b0;
    #1;
    chk("idle_ch_valid", 64'(ch_req_out.valid), 64'h0);

    // 1: all requesters reading, round-robin order then in-order routing
    req_enable = 4'hF; ch_req_grant_in = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 64'(i));
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t1_grant", 64'(req_grant_out), 64'(4'b0001 << (k % 4)));
      chk("t1_addr", ch_req_out.addr, 64'(k % 4));
      step();
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 64'h0);
    resp_grant_in = 4'hF;
    for (int k = 0; k < 5; k++) begin
      set_resp(1'b1, 64'(100 + k));
      #1;
      chk("t1_rvalid", 64'(resp_out[k % 4].valid), 64'h1);
      chk("t1_rdata", resp_out[k % 4].data[63:0], 64'(100 + k));
      chk("t1_chgrant", 64'(ch_resp_grant_out), 64'h1);
      step();
    end
    set_resp(1'b0, 64'h0);

    // 2: lone requester 2 with a stalled channel
    set_req(2, 1'b1, 1'b0, 64'h2);
    ch_req_grant_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_stall_grant", 64'(req_grant_out), 64'h0);
      chk("t2_stall_valid", 64'(ch_req_out.valid), 64'h1);
      step();
    end
    ch_req_grant_in = 1'b1;
    #1;
    chk("t2_grant", 64'(req_grant_out), 64'b0100);
    step();
    ch_req_grant_in = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 64'(i));
    #1;
    chk("t2_rrptr3", ch_req_out.addr, 64'h3);
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 64'h0);
    set_resp(1'b1, 64'h22);
    #1;
    chk("t2_route2", 64'(resp_out[2].valid), 64'h1);
    step();
    set_resp(1'b0, 64'h0);

    // 3: fill route FIFO, writes still pass, a pop frees a read next cycle
    ch_req_grant_in = 1'b1; resp_grant_in = 4'h0;
    set_req(0, 1'b1, 1'b0, 64'h10);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("t3_fill", 64'(req_grant_out), 64'b0001);
      step();
    end
    chk("t3_full_grant", 64'(req_grant_out), 64'h0);
    chk("t3_full_valid", 64'(ch_req_out.valid), 64'h0);
    set_req(1, 1'b1, 1'b1, 64'h11);
    #1;
    chk("t3_write", 64'(req_grant_out), 64'b0010);
    step();
    set_req(1, 1'b0, 1'b0, 64'h0);
    set_resp(1'b1, 64'h33); resp_grant_in = 4'b0001;
    #1;
    chk("t3_nobypass", 64'(req_grant_out), 64'h0);
    chk("t3_pop", 64'(ch_resp_grant_out), 64'h1);
    step();
    set_resp(1'b0, 64'h0);
    #1;
    chk("t3_after_pop", 64'(req_grant_out), 64'b0001);
    step();

    // 4: requester back-pressure holds the response and the FIFO count
    set_resp(1'b1, 64'hAB); resp_grant_in = 4'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_chgrant", 64'(ch_resp_grant_out), 64'h0);
      chk("t4_hold", resp_out[0].data[63:0], 64'hAB);
      chk("t4_full", 64'(req_grant_out), 64'h0);
      step();
    end
    resp_grant_in = 4'b0001;
    #1;
    chk("t4_accept", 64'(ch_resp_grant_out), 64'h1);
    step();
    set_resp(1'b0, 64'h0);
    #1;
    chk("t4_one_slot", 64'(req_grant_out), 64'b0001);
    step();
    chk("t4_refull", 64'(req_grant_out), 64'h0);
    set_req(0, 1'b0, 1'b0, 64'h0);
    resp_grant_in = 4'hF;
    set_resp(1'b1, 64'h44);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("t4_drain", 64'(resp_out[0].valid), 64'h1);
      step();
    end

    // 5: orphan response with empty FIFO
    #1;
    chk("t5_drop", 64'(ch_resp_grant_out), 64'h1);
    chk("t5_novalid", 64'(resp_out[0].valid | resp_out[1].valid | resp_out[2].valid | resp_out[3].valid), 64'h0);
    step();
    set_resp(1'b0, 64'h0);
    chk("t5_err", 64'(err_orphan_resp), 64'h1);
    step(); step();
    chk("t5_sticky", 64'(err_orphan_resp), 64'h1);

    // 6: grant statistics and reset mid-burst
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_err_clr", 64'(err_orphan_resp), 64'h0);
    ch_req_grant_in = 1'b1;
    set_req(0, 1'b1, 1'b1, 64'h60);
    for (int k = 0; k < 10; k++) step();
`ifdef AMI_ARB_STATS_EN
    exp_stat = 32'd10;
`else
    exp_stat = 32'd0;
`endif
    chk("t6_stat10", 64'(stat_grants[0]), 64'(exp_stat));
    chk("t6_stat1", 64'(stat_grants[1]), 64'h0);
    step(); step();
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", 64'(req_grant_out), 64'h0);
    chk("t6_rst_valid", 64'(ch_req_out.valid), 64'h0);
    step();
    chk("t6_rst_stat", 64'(stat_grants[0]), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 64'(i));
    #1;
    chk("t6_rrptr0", 64'(req_grant_out), 64'b0001);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
